// File: rtl/car_sensor_emulator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : car_sensor_pkg                                          |
// | Brief    : States, direction and sensor encodings shared by the    |
// |            parking-gate sensor emulator.                           |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package car_sensor_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_GAP  = 3'd4
  } t_emu_state;

  typedef enum logic {
    DIR_ENTER = 1'b0,
    DIR_EXIT  = 1'b1
  } t_dir;

  // Sensor encodings as {a,b}
  localparam logic [1:0] c_ab_clear  = 2'b00;
  localparam logic [1:0] c_ab_a_only = 2'b10;
  localparam logic [1:0] c_ab_both   = 2'b11;
  localparam logic [1:0] c_ab_b_only = 2'b01;

  // Sensor pattern a car produces in a given phase and direction.
  function automatic logic [1:0] f_sensor_ab(input t_emu_state s, input t_dir d);
    logic [1:0] v_ab;
    v_ab = c_ab_clear;
    case (s)
      S_P1:    v_ab = (d == DIR_ENTER) ? c_ab_a_only : c_ab_b_only;
      S_P2:    v_ab = c_ab_both;
      S_P3:    v_ab = (d == DIR_ENTER) ? c_ab_b_only : c_ab_a_only;
      default: v_ab = c_ab_clear;
    endcase
    return v_ab;
  endfunction

endpackage
`default_nettype wire

// File: rtl/car_sensor_emulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : car_sensor_emulator_if                                  |
// | Brief    : Control handshake and emulated sensor outputs of the    |
// |            car sensor emulator.                                    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface car_sensor_emulator_if #(
  parameter int DWELL_W = 8,
  parameter int COUNT_W = 8
);
  logic               i_start_enter;
  logic               i_start_exit;
  logic [DWELL_W-1:0] i_dwell;
  logic [COUNT_W-1:0] i_num_cars;
  logic               i_abort;
  logic               o_a;
  logic               o_b;
  logic               o_busy;
  logic               o_done;
  logic [COUNT_W-1:0] o_remaining;

  // Controller side: issues requests, observes sensors and status
  modport master (
    output i_start_enter, i_start_exit, i_dwell, i_num_cars, i_abort,
    input  o_a, o_b, o_busy, o_done, o_remaining
  );

  // Emulator side
  modport slave (
    input  i_start_enter, i_start_exit, i_dwell, i_num_cars, i_abort,
    output o_a, o_b, o_busy, o_done, o_remaining
  );
endinterface
`default_nettype wire

// File: rtl/car_sensor_emulator_phase_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : phase_timer                                             |
// | Brief    : Loadable down-counter with terminal-count flag; times   |
// |            both the dwell phases and the inter-car gap.            |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_value,
  output logic                  o_tc
);

  logic [WIDTH-1:0] r_count;

  // Load on phase entry, otherwise count down and hold at zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/car_sensor_emulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : car_sensor_emulator                                     |
// | Brief    : Emits N back-to-back two-sensor car waveforms in one    |
// |            direction with programmable dwell and fixed gap.        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module car_sensor_emulator
  import car_sensor_pkg::*;
#(
  parameter int DWELL_W    = 8,
  parameter int COUNT_W    = 8,
  parameter int GAP_CYCLES = 4
) (
  input wire logic              i_clk,
  input wire logic              i_rst,
  car_sensor_emulator_if.slave  bus
);

  // Gap length below one behaves as one; timer holds length-1.
  localparam int                 c_gap_eff  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam logic [DWELL_W-1:0] c_gap_load = DWELL_W'(c_gap_eff - 1);

  t_emu_state         r_state;
  t_emu_state         w_state_next;
  t_dir               r_dir;
  t_dir               w_dir_next;
  logic [DWELL_W-1:0] r_dwell_m1;
  logic [DWELL_W-1:0] w_dwell_m1_next;
  logic [COUNT_W-1:0] r_remaining;
  logic [COUNT_W-1:0] w_remaining_next;
  logic               w_done_next;
  logic               w_load;
  logic [DWELL_W-1:0] w_load_value;
  logic               w_tc;
  logic               w_start;
  logic [DWELL_W-1:0] w_start_dwell_m1;
  logic               r_a;
  logic               r_b;
  logic               r_busy;
  logic               r_done;

  // Dwell of zero is treated as one cycle, so D-1 is simply clamped at 0.
  assign w_start          = bus.i_start_enter | bus.i_start_exit;
  assign w_start_dwell_m1 = (bus.i_dwell == '0) ? '0 : (bus.i_dwell - 1'b1);

  phase_timer #(
    .WIDTH (DWELL_W)
  ) u_phase_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .o_tc         (w_tc)
  );

  // Next-state, timer reload and car bookkeeping
  always_comb begin
    w_state_next     = r_state;
    w_dir_next       = r_dir;
    w_dwell_m1_next  = r_dwell_m1;
    w_remaining_next = r_remaining;
    w_done_next      = 1'b0;
    w_load           = 1'b0;
    w_load_value     = r_dwell_m1;

    if (r_state == S_IDLE) begin
      // Abort outranks a start even when idle
      if (!bus.i_abort && w_start && (bus.i_num_cars != '0)) begin
        w_state_next     = S_P1;
        w_dir_next       = bus.i_start_enter ? DIR_ENTER : DIR_EXIT;
        w_dwell_m1_next  = w_start_dwell_m1;
        w_remaining_next = bus.i_num_cars;
        w_load           = 1'b1;
        w_load_value     = w_start_dwell_m1;
      end
    end else if (bus.i_abort) begin
      w_state_next     = S_IDLE;
      w_remaining_next = '0;
    end else if (w_tc) begin
      case (r_state)
        S_P1: begin
          w_state_next = S_P2;
          w_load       = 1'b1;
        end
        S_P2: begin
          w_state_next = S_P3;
          w_load       = 1'b1;
        end
        S_P3: begin
          w_state_next = S_GAP;
          w_load       = 1'b1;
          w_load_value = c_gap_load;
        end
        S_GAP: begin
          w_remaining_next = r_remaining - 1'b1;
          if (r_remaining == COUNT_W'(1)) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_P1;
            w_load       = 1'b1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs, derived from the upcoming state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_dir       <= DIR_ENTER;
      r_dwell_m1  <= '0;
      r_remaining <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_dir        <= w_dir_next;
      r_dwell_m1   <= w_dwell_m1_next;
      r_remaining  <= w_remaining_next;
      {r_a, r_b}   <= f_sensor_ab(w_state_next, w_dir_next);
      r_busy       <= (w_state_next != S_IDLE);
      r_done       <= w_done_next;
    end
  end

  assign bus.o_a         = r_a;
  assign bus.o_b         = r_b;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_remaining = r_remaining;

endmodule
`default_nettype wire

// File: doc/car_sensor_emulator.md
Name: car_sensor_emulator

Overview:
- Generates the two-sensor (a/b) blocking waveform that a parking-lot gate produces when a car passes, so the occupancy counter can be driven on-board and in benches without physical sensors.
- Emits N back-to-back cars in one direction with programmable per-phase dwell and a fixed inter-car gap, with a start/busy/done handshake.
- Sits upstream of parking_lot_occupancy_counter; o_a/o_b connect directly to its i_a/i_b.

Parameters:
- DWELL_W, 8, width of the per-phase dwell length input.
- COUNT_W, 8, width of the car-count input and the remaining-cars output.
- GAP_CYCLES, 4, cycles both sensors are clear between cars and after the last car (values below 1 behave as 1).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start_enter  in  1  request an entering sequence (sensor a first).
- i_start_exit  in  1  request an exiting sequence (sensor b first).
- i_dwell  in  DWELL_W  cycles per blocking phase; sampled at start.
- i_num_cars  in  COUNT_W  cars to emit; sampled at start.
- i_abort  in  1  cancel the sequence in progress.
- o_a  out  1  emulated sensor a (registered).
- o_b  out  1  emulated sensor b (registered).
- o_busy  out  1  a sequence is in progress.
- o_done  out  1  one-cycle pulse when the last car's gap completes.
- o_remaining  out  COUNT_W  cars not yet completed, including the current one.

Behaviour:
- Reset: one clock, synchronous, active-high; reset is checked on the clock edge. Reset forces the state to S_IDLE and sets o_a=0, o_b=0, o_busy=0, o_done=0, o_remaining=0. Reset mid-sequence abandons the sequence immediately and does not pulse o_done.
- All outputs are registered. No output is driven combinationally from an input.
- Start acceptance:
  - A start is accepted only in S_IDLE and only when i_num_cars != 0.
  - If i_start_enter and i_start_exit are both high, enter wins.
  - Starts asserted while busy are ignored, not queued.
- On acceptance:
  - Latch direction, D = max(i_dwell, 1) and N = i_num_cars.
  - On the next edge: o_busy=1, o_remaining=N, and phase P1 outputs appear.
- Per-car phase sequence (outputs shown as {a,b}):
  - Enter: P1 {1,0} for D cycles -> P2 {1,1} for D cycles -> P3 {0,1} for D cycles -> GAP {0,0} for GAP_CYCLES cycles.
  - Exit: P1 {0,1} for D cycles -> P2 {1,1} for D cycles -> P3 {1,0} for D cycles -> GAP {0,0} for GAP_CYCLES cycles.
  - Outputs change only at phase boundaries. A car therefore occupies exactly 3*D + GAP_CYCLES cycles.
- At the end of each GAP, o_remaining is decremented.
  - If the new value is nonzero, the next car's P1 starts on the following cycle with no extra idle cycle.
  - If it is zero, on that same edge: state -> S_IDLE, o_busy=0, o_done=1 for exactly one cycle.
- First-accept latency: start high at edge k -> o_a/o_b show P1 from edge k+1. Total busy time = N*(3*D + GAP_CYCLES) cycles.
- Abort (i_abort while busy):
  - On the next edge: o_a=0, o_b=0, o_busy=0, o_remaining=0, state -> S_IDLE; o_done is not pulsed.
  - The truncated car is not a valid pattern, so the downstream counter must not count it.
  - Abort while idle has no effect. Abort has priority over a start in the same cycle.
- Counters:
  - Phase timer is a down-counter of DWELL_W bits, loaded with D-1 (or GAP_CYCLES-1) on phase entry; the phase ends when it reaches 0.
  - The gap count must fit in the timer width: GAP_CYCLES <= 2^DWELL_W. D = 2^DWELL_W-1 must work without overflow.
- States: S_IDLE, S_P1, S_P2, S_P3, S_GAP. Direction is a latched bit that selects the output encoding for each state.

Decomposition:
- Package car_sensor_pkg:
  - t_emu_state enum {S_IDLE, S_P1, S_P2, S_P3, S_GAP}.
  - t_dir enum {DIR_ENTER, DIR_EXIT}.
  - Constant output encodings per (state, dir).
- One sub-module, phase_timer: loadable down-counter with a terminal-count flag, parameterised by width, shared by the dwell and gap phases.

Test Plan:
- Enter, D=3, N=1, GAP=4 -> {a,b} = 10×3, 11×3, 01×3, 00×4. o_done pulses once at cycle 13 after acceptance. Downstream counter sees one o_car_enter.
- Exit, D=1, N=3 -> three sequences 01,11,10,00×4, each 7 cycles with no idle between. o_remaining goes 3→2→1→0. Three o_car_exit pulses. o_busy is high for 21 cycles.
- Start enter and exit together with D=2, N=1 -> enter pattern (a first). Starts pulsed mid-sequence are ignored, and no second sequence follows.
- i_dwell=0 -> treated as D=1. i_num_cars=0 -> no acceptance: busy, outputs and done all stay 0.
- Abort during P2 of car 2 of N=4 -> next cycle a=b=0, busy=0, remaining=0, no done. Downstream counter has exactly one event.
- Synchronous reset asserted mid-P3 -> all outputs 0 on that edge. A subsequent start with D=2, N=1 produces a clean full pattern.
